// File: rtl/adj_button_ctrl.sv
// adj_button_ctrl: synchronise, debounce and strobe the time-adjust buttons.
// Define ADJ_BUTTON_AUTO_REPEAT_EN to make a held button keep stepping.
module adj_button_ctrl #(
  parameter int NUM_BTN        = 3,
  parameter int SAMPLE_DIV     = 16,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               sample_tick
);

  localparam int PW = $clog2(SAMPLE_DIV) + 1;
  localparam int SW = $clog2(STABLE_SAMPLES) + 1;

`ifdef ADJ_BUTTON_AUTO_REPEAT_EN
  localparam int REP_MAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(REP_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } st_t;
`else
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } st_t;
`endif

  if (NUM_BTN < 1 || SAMPLE_DIV < 2 || STABLE_SAMPLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("adj_button_ctrl: illegal parameter value");
  end

  logic [PW-1:0]      pre_cnt;
  logic [NUM_BTN-1:0] meta;
  logic [NUM_BTN-1:0] sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= (pre_cnt == PW'(SAMPLE_DIV - 1));
      if (pre_cnt == PW'(SAMPLE_DIV - 1))
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_in;
      sync <= meta;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    logic [SW-1:0] stab_cnt;
    logic          level_q;
    logic          flip;
    logic          lvl_d;
    logic          pulse_q;
    logic          pulse_nxt;
    st_t           state;
    st_t           state_nxt;

    // lvl_d is the level as it will be after this tick, so the first
    // pulse lands in the same cycle the debounced level rises.
    assign flip  = sample_tick && (sync[g] != level_q) &&
                   (stab_cnt == SW'(STABLE_SAMPLES - 1));
    assign lvl_d = level_q ^ flip;

    assign btn_level[g] = level_q;
    assign btn_pulse[g] = pulse_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stab_cnt <= '0;
        level_q  <= 1'b0;
      end else if (sample_tick) begin
        if (sync[g] == level_q || flip)
          stab_cnt <= '0;
        else
          stab_cnt <= stab_cnt + SW'(1);
        level_q <= lvl_d;
      end
    end

`ifdef ADJ_BUTTON_AUTO_REPEAT_EN
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nxt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        rep_cnt <= '0;
        pulse_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        rep_cnt <= rep_nxt;
        pulse_q <= pulse_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      rep_nxt   = rep_cnt;
      if (sample_tick) begin
        if (!lvl_d) begin
          state_nxt = IDLE;
          rep_nxt   = '0;
        end else begin
          unique case (state)
            IDLE: begin
              state_nxt = DELAY;
              rep_nxt   = '0;
            end
            DELAY: begin
              if (rep_cnt == RW'(REPEAT_DELAY - 1)) begin
                state_nxt = REPEAT;
                rep_nxt   = '0;
              end else begin
                rep_nxt = rep_cnt + RW'(1);
              end
            end
            REPEAT: begin
              if (rep_cnt == RW'(REPEAT_RATE - 1))
                rep_nxt = '0;
              else
                rep_nxt = rep_cnt + RW'(1);
            end
            default: begin
              state_nxt = IDLE;
              rep_nxt   = '0;
            end
          endcase
        end
      end
    end

    always_comb begin
      pulse_nxt = 1'b0;
      if (sample_tick && lvl_d) begin
        unique case (state)
          IDLE:    pulse_nxt = 1'b1;
          DELAY:   pulse_nxt = (rep_cnt == RW'(REPEAT_DELAY - 1));
          REPEAT:  pulse_nxt = (rep_cnt == RW'(REPEAT_RATE - 1));
          default: pulse_nxt = 1'b0;
        endcase
      end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        pulse_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        pulse_q <= pulse_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      if (sample_tick)
        state_nxt = lvl_d ? HELD : IDLE;
    end

    always_comb begin
      pulse_nxt = 1'b0;
      if (sample_tick && lvl_d && state == IDLE)
        pulse_nxt = 1'b1;
    end
`endif
  end

endmodule
